nibble_serial_adder_ctrl: RTL

//   Sequencer that adds WIDTH-bit operands through the team's existing 4-bit carry_look_ahead_adder.

---
 rtl/nibble_serial_adder_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds WIDTH-bit operands one nibble per clock through an external 4-bit CLA,
// chaining the carry through a register; valid/ready on both operand and result sides.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_carry
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              c_q, c_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        sum_d     = sum_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cla_a     = 4'd0;
        cla_b     = 4'd0;
        cla_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cla_a   = a_q[4*idx_q +: 4];
                cla_b   = b_q[4*idx_q +: 4];
                cla_cin = c_q;
                sum_d[4*idx_q +: 4] = cla_sum;
                c_d     = cla_carry;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // sum/cout come straight from the registers so they stay stable while DONE waits for out_ready
    assign sum  = sum_q;
    assign cout = c_q;
endmodule

// carry_look_ahead_adder: 4-bit adder with fully expanded generate/propagate carries.
module carry_look_ahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum   = p ^ c[3:0];
    assign carry = c[4];
endmodule
